// File: rtl/pll_phase_responder_if.sv
// Control/status bundle between a PLL phase-setter (master) and the phase responder (slave).
interface pll_phase_responder_if #(
  parameter int PHASE_W = 8,
  parameter int CNT_W   = 16
);
  logic                 areset;
  logic                 clkswitch;
  logic [2:0]           phasecounterselect;
  logic                 phaseupdown;
  logic                 phasestep;
  logic                 scanclk;
  logic                 phase_done;
  logic                 clk_sel;
  logic [PHASE_W-1:0]   phase_m;
  logic [5*PHASE_W-1:0] phase_c;
  logic [CNT_W-1:0]     step_count;
  logic                 busy;
  logic                 err;

  modport master (
    output areset, clkswitch, phasecounterselect, phaseupdown, phasestep, scanclk,
    input  phase_done, clk_sel, phase_m, phase_c, step_count, busy, err
  );

  modport slave (
    input  areset, clkswitch, phasecounterselect, phaseupdown, phasestep, scanclk,
    output phase_done, clk_sel, phase_m, phase_c, step_count, busy, err
  );
endinterface

// File: rtl/pll_phase_responder.sv
// Responder model of the PLL dynamic-phase-shift / clock-switch port: tracks M and C0..C4
// phase offsets, answers each phasestep with a phase_done pulse, and tracks the input-clock select.
module pll_phase_responder #(
  parameter int PHASE_W      = 8,
  parameter int DONE_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_phase_responder_if.slave  pif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic [2:0] SEL_ALL  = 3'b000;
  localparam logic [2:0] SEL_M    = 3'b001;
  localparam logic [2:0] SEL_BAD  = 3'b111;
  localparam logic [3:0] LAT_LAST = 4'(DONE_LATENCY);

  // One VCO step up or down; the accumulator wraps modulo 2^PHASE_W.
  function automatic logic signed [PHASE_W-1:0] wrap_step(
    input logic signed [PHASE_W-1:0] acc,
    input logic                      up
  );
    logic signed [PHASE_W-1:0] delta;
    delta = up ? {{(PHASE_W-1){1'b0}}, 1'b1} : {PHASE_W{1'b1}};
    return acc + delta;
  endfunction

  logic                      scanclk_q, scanclk_d;
  logic                      ps_q, ps_d;
  logic                      clkswitch_q, clkswitch_d;
  logic [0:0]                state_q, state_d;
  logic [3:0]                lat_q, lat_d;
  logic [2:0]                sel_q, sel_d;
  logic                      dir_q, dir_d;
  logic                      phase_done_q, phase_done_d;
  logic                      clk_sel_q, clk_sel_d;
  logic signed [PHASE_W-1:0] acc_m_q, acc_m_d;
  logic signed [PHASE_W-1:0] acc_c_q [5];
  logic signed [PHASE_W-1:0] acc_c_d [5];
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic sr;
  logic se;
  logic csw_rise;
  logic lat_hit;

  assign sr       = pif.scanclk & ~scanclk_q;
  assign se       = sr & pif.phasestep & ~ps_q;
  assign csw_rise = pif.clkswitch & ~clkswitch_q;
  assign lat_hit  = (lat_q + 4'd1) == LAT_LAST;

  always_comb begin
    scanclk_d    = pif.scanclk;
    clkswitch_d  = pif.clkswitch;
    ps_d         = sr ? pif.phasestep : ps_q;
    state_d      = state_q;
    lat_d        = lat_q;
    sel_d        = sel_q;
    dir_d        = dir_q;
    phase_done_d = phase_done_q;
    clk_sel_d    = clk_sel_q;
    acc_m_d      = acc_m_q;
    acc_c_d      = acc_c_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    if (pif.areset) begin
      // PLL reset wins over every step and clock-switch event; the step counter survives it.
      state_d      = ST_IDLE;
      lat_d        = 4'd0;
      phase_done_d = 1'b1;
      clk_sel_d    = 1'b0;
      err_d        = 1'b0;
      acc_m_d      = '0;
      for (int i = 0; i < 5; i++) acc_c_d[i] = '0;
    end else begin
      if (csw_rise) clk_sel_d = ~clk_sel_q;

      case (state_q)
        ST_IDLE: begin
          if (se) begin
            sel_d        = pif.phasecounterselect;
            dir_d        = pif.phaseupdown;
            phase_done_d = 1'b0;
            lat_d        = 4'd0;
            state_d      = ST_BUSY;
            if (pif.phasecounterselect == SEL_BAD) err_d = 1'b1;
          end
        end
        ST_BUSY: begin
          if (se) err_d = 1'b1;
          if (sr) begin
            lat_d = lat_q + 4'd1;
            if (lat_hit) begin
              // Step lands on the same edge phase_done returns, so a sampled high means applied.
              if (sel_q != SEL_BAD) begin
                if (sel_q == SEL_M) acc_m_d = wrap_step(acc_m_q, dir_q);
                for (int i = 0; i < 5; i++) begin
                  if ((sel_q == SEL_ALL) || (sel_q == 3'(i + 2)))
                    acc_c_d[i] = wrap_step(acc_c_q[i], dir_q);
                end
                cnt_d = cnt_q + 1'b1;
              end
              phase_done_d = 1'b1;
              lat_d        = 4'd0;
              state_d      = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanclk_q    <= 1'b0;
      ps_q         <= 1'b0;
      clkswitch_q  <= 1'b0;
      state_q      <= ST_IDLE;
      lat_q        <= 4'd0;
      phase_done_q <= 1'b1;
      clk_sel_q    <= 1'b0;
      acc_m_q      <= '0;
      for (int i = 0; i < 5; i++) acc_c_q[i] <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      scanclk_q    <= scanclk_d;
      ps_q         <= ps_d;
      clkswitch_q  <= clkswitch_d;
      state_q      <= state_d;
      lat_q        <= lat_d;
      phase_done_q <= phase_done_d;
      clk_sel_q    <= clk_sel_d;
      acc_m_q      <= acc_m_d;
      acc_c_q      <= acc_c_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Latched select/direction are pure data captured with the step; no reset needed.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    dir_q <= dir_d;
  end

  assign pif.phase_done = phase_done_q;
  assign pif.clk_sel    = clk_sel_q;
  assign pif.phase_m    = acc_m_q;
  assign pif.step_count = cnt_q;
  assign pif.busy       = (state_q == ST_BUSY);
  assign pif.err        = err_q;

  for (genvar g = 0; g < 5; g++) begin : g_pack
    assign pif.phase_c[g*PHASE_W +: PHASE_W] = acc_c_q[g];
  end

endmodule

// File: tb/tb_pll_phase_responder.sv
// Scoreboard bench for pll_phase_responder: a small reference model predicts the state at each
// phase_done rise; a monitor pops and compares when the DUT completes.
module tb_pll_phase_responder;

  localparam int PW = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic [PW-1:0]   m;
    logic [5*PW-1:0] c;
    logic [CW-1:0]   cnt;
    logic            err;
  } snap_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pll_phase_responder_if #(.PHASE_W(PW), .CNT_W(CW)) pif ();

  pll_phase_responder #(.PHASE_W(PW), .DONE_LATENCY(2), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] m_m;
  logic [PW-1:0] m_c [5];
  logic [CW-1:0] m_cnt;
  logic          m_err;
  snap_t         sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t cur_snap();
    snap_t s;
    s.m   = m_m;
    s.c   = {m_c[4], m_c[3], m_c[2], m_c[1], m_c[0]};
    s.cnt = m_cnt;
    s.err = m_err;
    return s;
  endfunction

  task automatic model_zero_acc();
    m_m = '0;
    for (int i = 0; i < 5; i++) m_c[i] = '0;
  endtask

  task automatic model_apply(input logic [2:0] sel, input logic dir);
    logic [PW-1:0] d;
    d = dir ? 8'h01 : 8'hFF;
    if (sel == 3'd7) begin
      m_err = 1'b1;
    end else begin
      if (sel == 3'd1) m_m = m_m + d;
      for (int i = 0; i < 5; i++)
        if (sel == 3'd0 || sel == 3'(i + 2)) m_c[i] = m_c[i] + d;
      m_cnt = m_cnt + 1'b1;
    end
  endtask

  // Monitor: every phase_done rise must match the oldest predicted snapshot.
  logic done_prev;
  initial done_prev = 1'b1;
  always @(negedge clk) begin
    if (!done_prev && pif.phase_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        snap_t e;
        e = sb.pop_front();
        chk("sb_phase_m", 64'(pif.phase_m), 64'(e.m));
        chk("sb_phase_c", 64'(pif.phase_c), 64'(e.c));
        chk("sb_step_count", 64'(pif.step_count), 64'(e.cnt));
        chk("sb_err", 64'(pif.err), 64'(e.err));
      end
    end
    done_prev = pif.phase_done;
  end

  task automatic scan_cycle();
    pif.scanclk = 1'b1;
    repeat (3) @(negedge clk);
    pif.scanclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic scan_rise_sample(output logic d);
    pif.scanclk = 1'b1;
    @(posedge clk);
    #1 d = pif.phase_done;
    repeat (3) @(negedge clk);
    pif.scanclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 12 && !(pif.phase_done === 1'b1 && pif.busy === 1'b0); k++) scan_cycle();
    @(negedge clk);
    chk(tag, 64'(pif.phase_done & ~pif.busy), 64'd1);
  endtask

  task automatic do_step(input logic [2:0] sel, input logic dir, input int hold);
    model_apply(sel, dir);
    sb.push_back(cur_snap());
    pif.phasecounterselect = sel;
    pif.phaseupdown        = dir;
    pif.phasestep          = 1'b1;
    repeat (hold) scan_cycle();
    pif.phasestep = 1'b0;
    scan_cycle();
    wait_idle("step_idle");
  endtask

  task automatic pulse_areset();
    @(negedge clk);
    pif.areset = 1'b1;
    @(negedge clk);
    pif.areset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d;
    int   toggles;
    logic prev_sel;
    logic [2:0] seq_sel [6];
    int         seq_cnt [6];
    logic       seq_dir [6];

    n_vec = 0;
    n_err = 0;
    seq_sel = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    seq_cnt = '{3, 2, 2, 1, 2, 1};
    seq_dir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    pif.areset = 1'b0;
    pif.clkswitch = 1'b0;
    pif.phasecounterselect = 3'd0;
    pif.phaseupdown = 1'b0;
    pif.phasestep = 1'b0;
    pif.scanclk = 1'b0;
    model_zero_acc();
    m_cnt = '0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase_done", 64'(pif.phase_done), 64'd1);
    chk("rst_busy", 64'(pif.busy), 64'd0);
    chk("rst_phase_c", 64'(pif.phase_c), 64'd0);
    chk("rst_step_count", 64'(pif.step_count), 64'd0);
    chk("rst_clk_sel", 64'(pif.clk_sel), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single C0 up step with phasestep held over three scanclk periods.
    model_apply(3'd2, 1'b1);
    sb.push_back(cur_snap());
    pif.phasecounterselect = 3'd2;
    pif.phaseupdown = 1'b1;
    pif.phasestep = 1'b1;
    chk("t1_done_pre", 64'(pif.phase_done), 64'd1);
    scan_rise_sample(d);
    chk("t1_done_fall", 64'(d), 64'd0);
    chk("t1_busy", 64'(pif.busy), 64'd1);
    scan_rise_sample(d);
    chk("t1_done_lat1", 64'(d), 64'd0);
    scan_rise_sample(d);
    chk("t1_done_rise", 64'(d), 64'd1);
    chk("t1_c0", 64'(pif.phase_c[7:0]), 64'd1);
    pif.phasestep = 1'b0;
    scan_cycle();
    @(negedge clk);
    chk("t1_count", 64'(pif.step_count), 64'd1);

    // Six selection sequences from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_zero_acc();
    m_cnt = '0;
    m_err = 1'b0;
    for (int s = 0; s < 6; s++)
      for (int n = 0; n < seq_cnt[s]; n++) do_step(seq_sel[s], seq_dir[s], 1);
    chk("t2_c0", 64'(pif.phase_c[7:0]), 64'd5);
    chk("t2_c1", 64'(pif.phase_c[15:8]), 64'd5);
    chk("t2_c2", 64'(pif.phase_c[23:16]), 64'd2);
    chk("t2_c3", 64'(pif.phase_c[31:24]), 64'd5);
    chk("t2_c4", 64'(pif.phase_c[39:32]), 64'd2);
    chk("t2_m", 64'(pif.phase_m), 64'd0);
    chk("t2_count", 64'(pif.step_count), 64'd11);

    // Wrap: C1 down from 0, then a full 256-step revolution up.
    pulse_areset();
    model_zero_acc();
    m_err = 1'b0;
    chk("t3_c1_zero", 64'(pif.phase_c[15:8]), 64'd0);
    chk("t3_count_kept", 64'(pif.step_count), 64'd11);
    do_step(3'd3, 1'b0, 1);
    chk("t3_c1_down", 64'(pif.phase_c[15:8]), 64'hFF);
    for (int n = 0; n < 256; n++) do_step(3'd3, 1'b1, 1);
    chk("t3_c1_wrap", 64'(pif.phase_c[15:8]), 64'hFF);
    do_step(3'd1, 1'b1, 1);
    chk("t3_m_up", 64'(pif.phase_m), 64'd1);

    // New phasestep edge while busy: error, but only the first step lands.
    model_apply(3'd2, 1'b1);
    m_err = 1'b1;
    sb.push_back(cur_snap());
    pif.phasecounterselect = 3'd2;
    pif.phaseupdown = 1'b1;
    pif.phasestep = 1'b1;
    scan_cycle();
    pif.phasestep = 1'b0;
    pif.phasecounterselect = 3'd4;
    scan_cycle();
    pif.phasestep = 1'b1;
    scan_cycle();
    pif.phasestep = 1'b0;
    scan_cycle();
    wait_idle("t4_idle");
    chk("t4_err", 64'(pif.err), 64'd1);
    chk("t4_count", 64'(pif.step_count), 64'(m_cnt));
    chk("t4_c2_untouched", 64'(pif.phase_c[23:16]), 64'd0);

    // PLL reset in the middle of a step.
    model_zero_acc();
    m_err = 1'b0;
    sb.push_back(cur_snap());
    pif.phasecounterselect = 3'd4;
    pif.phaseupdown = 1'b1;
    pif.phasestep = 1'b1;
    scan_cycle();
    chk("t5_busy_before", 64'(pif.busy), 64'd1);
    pif.areset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_done", 64'(pif.phase_done), 64'd1);
    chk("t5_busy", 64'(pif.busy), 64'd0);
    chk("t5_err", 64'(pif.err), 64'd0);
    @(negedge clk);
    pif.areset = 1'b0;
    pif.phasestep = 1'b0;
    repeat (3) scan_cycle();
    chk("t5_phase_c", 64'(pif.phase_c), 64'd0);
    chk("t5_count_kept", 64'(pif.step_count), 64'(m_cnt));

    // Invalid select: done pulses, nothing applied, sticky error.
    do_step(3'd7, 1'b1, 1);
    chk("t6_err", 64'(pif.err), 64'd1);
    chk("t6_phase_c", 64'(pif.phase_c), 64'd0);

    // Clock switch held for 8 cycles toggles exactly once.
    chk("t7_sel_pre", 64'(pif.clk_sel), 64'd0);
    toggles = 0;
    prev_sel = pif.clk_sel;
    pif.clkswitch = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 7) pif.clkswitch = 1'b0;
      if (pif.clk_sel !== prev_sel) toggles++;
      prev_sel = pif.clk_sel;
    end
    chk("t7_toggles", 64'(toggles), 64'd1);
    chk("t7_sel_post", 64'(pif.clk_sel), 64'd1);

    // Asynchronous reset mid-step.
    model_zero_acc();
    m_cnt = '0;
    m_err = 1'b0;
    sb.push_back(cur_snap());
    pif.phasecounterselect = 3'd2;
    pif.phaseupdown = 1'b1;
    pif.phasestep = 1'b1;
    scan_cycle();
    chk("t8_busy_before", 64'(pif.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_done", 64'(pif.phase_done), 64'd1);
    chk("t8_busy", 64'(pif.busy), 64'd0);
    chk("t8_count", 64'(pif.step_count), 64'd0);
    chk("t8_clk_sel", 64'(pif.clk_sel), 64'd0);
    chk("t8_err", 64'(pif.err), 64'd0);
    @(negedge clk);
    pif.phasestep = 1'b0;
    rst_n = 1'b1;
    repeat (2) scan_cycle();
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_phase_responder.md
Name: pll_phase_responder

Overview:
Synthesizable model of the PLL dynamic-phase-shift and clock-switch control port. It is the responder to the phase-setter state machine that drives areset/clkswitch/phasecounterselect/phaseupdown/phasestep/scanclk and waits on phase_done. It tracks the accumulated phase offset of M and C0..C4, generates phase_done with PLL-like latency, and tracks the selected input clock. It is used in benches and in on-chip self-check, where it sits beside the real PLL and its accumulators are read back over the readout path.

Parameters:
PHASE_W, 8, width of each per-counter signed phase accumulator in VCO steps; wraps modulo 2^PHASE_W.
DONE_LATENCY, 2, scanclk rising edges after step capture until phase_done returns high; legal range 1..15.
CNT_W, 16, width of the applied-step counter.

Ports:
clk  input  1  system clock; all inputs are synchronous to it.
rst_n  input  1  asynchronous active-low reset.
areset  input  1  PLL reset request, active high, synchronous.
clkswitch  input  1  manual clock-switch request, active high.
phasecounterselect  input  3  000 all C0..C4, 001 M, 010..110 C0..C4, 111 invalid.
phaseupdown  input  1  1 up (+1), 0 down (-1).
phasestep  input  1  step request.
scanclk  input  1  PLL scan clock, generated in the clk domain.
phase_done  output  1  low while a step is in progress.
clk_sel  output  1  0 inclk0, 1 inclk1.
phase_m  output  PHASE_W  M accumulator, two's complement.
phase_c  output  5*PHASE_W  C0 accumulator at bits [PHASE_W-1:0], C4 at the top.
step_count  output  CNT_W  number of applied steps; wraps.
busy  output  1  high while in BUSY state.
err  output  1  sticky protocol error.

Behaviour:
- rst_n low, asynchronous: phase_done=1, clk_sel=0, all accumulators=0, step_count=0, busy=0, err=0, state IDLE. Internal scanclk_q, ps_q and clkswitch_q are cleared to 0.
- Edge detection:
  - scanclk rise (sr) = scanclk & ~scanclk_q; scanclk_q is registered every clk cycle.
  - ps_q is updated only on sr cycles.
  - step edge (se) = sr & phasestep & ~ps_q. A level held across several scanclk edges counts as one step.
- areset high, any state: accumulators=0, state IDLE, phase_done=1, clk_sel=0, err=0. step_count is kept. All step and clkswitch events in that cycle are ignored. areset outranks every other event.
- clkswitch: on a rising edge (clkswitch & ~clkswitch_q) with areset low, clk_sel toggles on the next cycle. This is independent of the step FSM.
- FSM, IDLE:
  - on se, latch sel/dir. phase_done goes 0 and busy goes 1 on the next clk edge. Go to BUSY with lat=0.
  - If the latched sel=111: set err. phase_done still pulses, but no accumulator changes and step_count does not increment.
- FSM, BUSY:
  - each sr increments lat.
  - On the sr where lat reaches DONE_LATENCY: apply the step, step_count+=1, phase_done=1, busy=0, return to IDLE. All of these take effect on the same clk edge.
  - Apply step: add +1 or -1 (by dir) to the selected accumulator. For sel=000, add to all five C accumulators; M is unchanged. Arithmetic wraps modulo 2^PHASE_W.
  - se during BUSY: set err; the step is not queued.
- Latency: the initiator samples phase_done after the DONE_LATENCY-th scanclk rising edge following capture. A sampled high therefore means the step is already applied.
- Changes to phasecounterselect or phaseupdown while BUSY have no effect, because both are latched at capture.

Test Plan:
- Reset, then sel=010, dir=1, phasestep held for 3 scanclk periods. phase_done falls one clk after capture and rises on the 2nd following sr. C0 accumulator (phase_c[7:0]) becomes 1, step_count becomes 1, exactly one step counted.
- Six sequences through all/C0/C1/C2/C3/C4, with counts 3/2/2/1/2/1, dir pattern 1,1,1,0,1,0, each step followed by deassert. Required result: C0=5, C1=5, C2=2, C3=5, C4=2, M=0, step_count=11.
- C1 stepped down from 0 once -> phase_c[15:8]=8'hFF. Then 256 up steps -> 8'hFF again, confirming wrap.
- New phasestep rising edge while busy=1 -> err=1, no extra step applied. Invalid sel=111 -> err=1, phase_done pulses, accumulators unchanged.
- areset pulse during BUSY -> accumulators 0, phase_done=1 next cycle, err=0, step_count kept. clkswitch held for 8 cycles -> clk_sel toggles exactly once. rst_n low mid-step -> all outputs return to reset values immediately, without waiting for a clk edge.
